// File: rtl/exu_mul_pipe.sv
// Pipelined integer multiplier for the EXU: parametrised width and depth, RV64 word ops,
// flush, tag tracking and load-result bypass into E1.
module exu_mul_pipe #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned STAGES = 3,
  parameter int unsigned TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             freeze,
  input  logic             flush,
  input  logic             valid_in,
  input  logic             rs1_sign,
  input  logic             rs2_sign,
  input  logic             low,
  input  logic             word,
  input  logic             byp_rs1,
  input  logic             byp_rs2,
  input  logic [TAG_W-1:0] tag_in,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  input  logic [XLEN-1:0]  lsu_result,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag,
  output logic [XLEN-1:0]  out,
  output logic             busy
);

  localparam int unsigned PW = 2 * XLEN;
  // Product registers E3..E(STAGES); the last one feeds the result mux.
  localparam int unsigned NP = STAGES - 2;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             rs1_sign;
    logic             rs2_sign;
    logic             low;
    logic             word;
    logic             byp_rs1;
    logic             byp_rs2;
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
  } e1_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             low;
    logic             word;
    logic [XLEN:0]    ax;
    logic [XLEN:0]    bx;
  } e2_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             low;
    logic             word;
    logic [PW-1:0]    prod;
  } ep_t;

  logic [STAGES-1:0] vld_q, vld_d;
  e1_t               e1_q, e1_d;
  e2_t               e2_q, e2_d;
  ep_t               ep_q [NP];
  ep_t               ep_d [NP];

  logic [XLEN-1:0]   a_sel, b_sel;
  logic              word_eff;
  logic signed [PW-1:0] ax_w, bx_w;
  logic [PW-1:0]     prod;
  ep_t               last;

  // Extend to XLEN+1 bits so signed and unsigned operands share one signed multiplier.
  function automatic logic [XLEN:0] ext(input logic [XLEN-1:0] x, input logic sgn,
                                        input logic w);
    logic [XLEN-1:0] xw;
    if (w) begin
      if (sgn) xw = XLEN'($signed(x[31:0]));
      else     xw = XLEN'(x[31:0]);
    end else begin
      xw = x;
    end
    return {sgn & xw[XLEN-1], xw};
  endfunction

  always_comb begin
    a_sel    = e1_q.byp_rs1 ? lsu_result : e1_q.a;
    b_sel    = e1_q.byp_rs2 ? lsu_result : e1_q.b;
    word_eff = e1_q.word && (XLEN == 64);
    // Low 2*XLEN bits of the (XLEN+1)x(XLEN+1) signed product; upper bits are never selected.
    ax_w     = PW'($signed(e2_q.ax));
    bx_w     = PW'($signed(e2_q.bx));
    prod     = ax_w * bx_w;
  end

  always_comb begin
    vld_d = vld_q;
    e1_d  = e1_q;
    e2_d  = e2_q;
    for (int k = 0; k < NP; k++) ep_d[k] = ep_q[k];

    if (flush)        vld_d = '0;
    else if (!freeze) vld_d = {vld_q[STAGES-2:0], valid_in};

    // Data regs only move when a valid op moves into them.
    if (!freeze) begin
      if (valid_in) begin
        e1_d.tag      = tag_in;
        e1_d.rs1_sign = rs1_sign;
        e1_d.rs2_sign = rs2_sign;
        e1_d.low      = low;
        e1_d.word     = word;
        e1_d.byp_rs1  = byp_rs1;
        e1_d.byp_rs2  = byp_rs2;
        e1_d.a        = a;
        e1_d.b        = b;
      end
      if (vld_q[0]) begin
        e2_d.tag  = e1_q.tag;
        e2_d.low  = e1_q.low;
        e2_d.word = word_eff;
        e2_d.ax   = ext(a_sel, e1_q.rs1_sign, word_eff);
        e2_d.bx   = ext(b_sel, e1_q.rs2_sign, word_eff);
      end
      if (vld_q[1]) begin
        ep_d[0].tag  = e2_q.tag;
        ep_d[0].low  = e2_q.low;
        ep_d[0].word = e2_q.word;
        ep_d[0].prod = prod;
      end
      for (int k = 1; k < NP; k++) begin
        if (vld_q[k+1]) ep_d[k] = ep_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      vld_q <= '0;
      e1_q  <= '0;
      e2_q  <= '0;
      for (int k = 0; k < NP; k++) ep_q[k] <= '0;
    end else begin
      vld_q <= vld_d;
      e1_q  <= e1_d;
      e2_q  <= e2_d;
      for (int k = 0; k < NP; k++) ep_q[k] <= ep_d[k];
    end
  end

  always_comb begin
    last = ep_q[NP-1];
    if (last.word) begin
      if (last.low) out = XLEN'($signed(last.prod[31:0]));
      else          out = XLEN'($signed(last.prod[63:32]));
    end else begin
      if (last.low) out = last.prod[XLEN-1:0];
      else          out = last.prod[2*XLEN-1:XLEN];
    end
    out_tag   = last.tag;
    out_valid = vld_q[STAGES-1];
    busy      = |vld_q;
  end

endmodule

// File: tb/tb_exu_mul_pipe.sv
// Directed bench for exu_mul_pipe: three 32-bit instances (STAGES 3/4/5) and one 64-bit
// instance share control inputs; expected values are hand-computed constants.
module tb_exu_mul_pipe;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_l, freeze, flush, valid_in, rs1_sign, rs2_sign, low, word, byp_rs1, byp_rs2;
  logic [4:0]  tag_in;
  logic [31:0] a, b, lsu;
  logic [63:0] a64, b64, lsu64;

  logic        ov3, ov4, ov5, ov64, bz3, bz4, bz5, bz64;
  logic [4:0]  ot3, ot4, ot5, ot64;
  logic [31:0] o3, o4, o5;
  logic [63:0] o64;

  int tests = 0;
  int fails = 0;

  exu_mul_pipe #(.XLEN(32), .STAGES(3), .TAG_W(5)) u3 (
    .clk(clk), .rst_l(rst_l), .freeze(freeze), .flush(flush), .valid_in(valid_in),
    .rs1_sign(rs1_sign), .rs2_sign(rs2_sign), .low(low), .word(word), .byp_rs1(byp_rs1),
    .byp_rs2(byp_rs2), .tag_in(tag_in), .a(a), .b(b), .lsu_result(lsu),
    .out_valid(ov3), .out_tag(ot3), .out(o3), .busy(bz3));

  exu_mul_pipe #(.XLEN(32), .STAGES(4), .TAG_W(5)) u4 (
    .clk(clk), .rst_l(rst_l), .freeze(freeze), .flush(flush), .valid_in(valid_in),
    .rs1_sign(rs1_sign), .rs2_sign(rs2_sign), .low(low), .word(word), .byp_rs1(byp_rs1),
    .byp_rs2(byp_rs2), .tag_in(tag_in), .a(a), .b(b), .lsu_result(lsu),
    .out_valid(ov4), .out_tag(ot4), .out(o4), .busy(bz4));

  exu_mul_pipe #(.XLEN(32), .STAGES(5), .TAG_W(5)) u5 (
    .clk(clk), .rst_l(rst_l), .freeze(freeze), .flush(flush), .valid_in(valid_in),
    .rs1_sign(rs1_sign), .rs2_sign(rs2_sign), .low(low), .word(word), .byp_rs1(byp_rs1),
    .byp_rs2(byp_rs2), .tag_in(tag_in), .a(a), .b(b), .lsu_result(lsu),
    .out_valid(ov5), .out_tag(ot5), .out(o5), .busy(bz5));

  exu_mul_pipe #(.XLEN(64), .STAGES(3), .TAG_W(5)) u64 (
    .clk(clk), .rst_l(rst_l), .freeze(freeze), .flush(flush), .valid_in(valid_in),
    .rs1_sign(rs1_sign), .rs2_sign(rs2_sign), .low(low), .word(word), .byp_rs1(byp_rs1),
    .byp_rs2(byp_rs2), .tag_in(tag_in), .a(a64), .b(b64), .lsu_result(lsu64),
    .out_valid(ov64), .out_tag(ot64), .out(o64), .busy(bz64));

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", nm, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic s1, input logic s2, input logic lo, input logic w,
                       input logic b1, input logic b2, input logic [4:0] t,
                       input logic [63:0] x, input logic [63:0] y);
    valid_in = 1'b1;
    rs1_sign = s1;
    rs2_sign = s2;
    low      = lo;
    word     = w;
    byp_rs1  = b1;
    byp_rs2  = b2;
    tag_in   = t;
    a64      = x;
    b64      = y;
    a        = x[31:0];
    b        = y[31:0];
    step(1);
    valid_in = 1'b0;
  endtask

  logic [5:0] exp_v;
  logic [4:0] exp_t [6];

  initial begin
    rst_l = 1'b0; freeze = 1'b0; flush = 1'b0; valid_in = 1'b0;
    rs1_sign = 1'b0; rs2_sign = 1'b0; low = 1'b0; word = 1'b0; byp_rs1 = 1'b0; byp_rs2 = 1'b0;
    tag_in = '0; a = '0; b = '0; lsu = '0; a64 = '0; b64 = '0; lsu64 = '0;
    step(2);
    chk("rst_valid", 64'(ov3), 64'd0);
    chk("rst_out",   64'(o3),  64'd0);
    chk("rst_tag",   64'(ot3), 64'd0);
    chk("rst_busy",  64'(bz5), 64'd0);
    rst_l = 1'b1;
    step(1);

    // MULHSU and its low half
    issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 64'hFFFF_FFFF, 64'hFFFF_FFFF);
    chk("mulhsu_busy", 64'(bz3), 64'd1);
    step(2);
    chk("mulhsu_valid", 64'(ov3), 64'd1);
    chk("mulhsu_out",   64'(o3),  64'hFFFF_FFFF);
    chk("mulhsu_tag",   64'(ot3), 64'd1);
    step(1);
    chk("mulhsu_vdrop", 64'(ov3), 64'd0);
    chk("mulhsu_hold",  64'(o3),  64'hFFFF_FFFF);
    issue(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd2, 64'hFFFF_FFFF, 64'hFFFF_FFFF);
    step(2);
    chk("mulhsu_lo_out", 64'(o3), 64'h1);
    step(4);

    // MULHU latency across depths
    issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 64'hFFFF_FFFF, 64'hFFFF_FFFF);
    step(1);
    chk("lat3_early", 64'(ov3), 64'd0);
    step(1);
    chk("lat3_valid", 64'(ov3), 64'd1);
    chk("lat3_out",   64'(o3),  64'hFFFF_FFFE);
    chk("lat4_early", 64'(ov4), 64'd0);
    step(1);
    chk("lat4_valid", 64'(ov4), 64'd1);
    chk("lat4_out",   64'(o4),  64'hFFFF_FFFE);
    chk("lat5_early", 64'(ov5), 64'd0);
    step(1);
    chk("lat5_valid", 64'(ov5), 64'd1);
    chk("lat5_out",   64'(o5),  64'hFFFF_FFFE);
    step(4);

    // Back-to-back with a 2-cycle freeze while op 2 is in E2 (checked on the 5-stage unit)
    issue(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 64'd1, 64'd10);
    issue(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd2, 64'd2, 64'd10);
    issue(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 64'd3, 64'd10);
    freeze = 1'b1;
    step(2);
    freeze = 1'b0;
    exp_v = 6'b011100;
    exp_t[0] = 5'd0; exp_t[1] = 5'd0; exp_t[2] = 5'd1;
    exp_t[3] = 5'd2; exp_t[4] = 5'd3; exp_t[5] = 5'd3;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("frz_valid%0d", i), 64'(ov5), 64'(exp_v[i]));
      if (exp_v[i]) begin
        chk($sformatf("frz_tag%0d", i), 64'(ot5), 64'(exp_t[i]));
        chk($sformatf("frz_out%0d", i), 64'(o5),  64'(exp_t[i]) * 64'd10);
      end
      step(1);
    end
    step(2);

    // Flush with two ops in flight and a third presented alongside it
    issue(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd4, 64'd2, 64'd3);
    issue(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 64'd4, 64'd5);
    flush = 1'b1;
    issue(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd6, 64'd8, 64'd9);
    flush = 1'b0;
    chk("flush_valid", 64'(ov3), 64'd0);
    chk("flush_busy3", 64'(bz3), 64'd0);
    chk("flush_busy5", 64'(bz5), 64'd0);
    issue(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd7, 64'd6, 64'd7);
    chk("post_flush_v1", 64'(ov3), 64'd0);
    step(1);
    chk("post_flush_v2", 64'(ov3), 64'd0);
    step(1);
    chk("post_flush_valid", 64'(ov3), 64'd1);
    chk("post_flush_tag",   64'(ot3), 64'd7);
    chk("post_flush_out",   64'(o3),  64'd42);
    step(4);

    // Load-result bypass into rs1 during E1
    issue(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd8, 64'd3, 64'd5);
    lsu = 32'd7;
    step(1);
    lsu = 32'd0;
    step(1);
    chk("byp_valid", 64'(ov3), 64'd1);
    chk("byp_out",   64'(o3),  64'd35);
    step(4);

    // RV64 MULW; the 32-bit unit ignores word
    issue(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd9, 64'hFFFF_0000_4000_0000, 64'd2);
    step(2);
    chk("mulw_valid", 64'(ov64), 64'd1);
    chk("mulw_out",   o64, 64'hFFFF_FFFF_8000_0000);
    chk("mulw_tag",   64'(ot64), 64'd9);
    chk("w32_out",    64'(o3), 64'h8000_0000);
    step(2);

    // Reset mid-stream
    issue(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd10, 64'd5, 64'd5);
    issue(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd11, 64'd6, 64'd6);
    rst_l = 1'b0;
    #1;
    chk("midrst_valid", 64'(ov64), 64'd0);
    chk("midrst_out",   o64, 64'd0);
    chk("midrst_tag",   64'(ot64), 64'd0);
    chk("midrst_busy",  64'(bz64), 64'd0);
    chk("midrst_out3",  64'(o3), 64'd0);
    step(2);
    rst_l = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("postrst_v64_%0d", i), 64'(ov64), 64'd0);
      chk($sformatf("postrst_v5_%0d", i),  64'(ov5),  64'd0);
      step(1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
